// File: rtl/wb_pipe_monitor.sv
// Passive protocol monitor for a pipelined Wishbone B4 slave port.
// Define WB_MON_RMW_EN to allow idle gaps inside CYC (rule 8 off).
module wb_pipe_monitor #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_REQUESTS  = 8,
  parameter int MAX_STALL     = 4,
  parameter int MAX_ACK_DELAY = 8,
  localparam int SEL_W = DATA_W / 8,
  localparam int OUT_W = $clog2(MAX_REQUESTS + 1) + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [ADDR_W-1:0] ADR_I,
  input  logic [SEL_W-1:0]  SEL_I,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic              STALL_O,
  input  logic              ACK_O,
  input  logic              ERR_O,
  input  logic              clear_i,
  output logic [8:0]        viol_o,
  output logic [3:0]        first_viol_o,
  output logic [OUT_W-1:0]  outstanding_o,
  output logic [15:0]       xact_cnt_o
);

  localparam int CNT_W = $clog2(2 * MAX_REQUESTS + 1);
  localparam int STL_W = $clog2(MAX_STALL + 2);
  localparam int DLY_W = $clog2(MAX_ACK_DELAY + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * MAX_REQUESTS);
  localparam logic [CNT_W-1:0] REQ_LIM = CNT_W'(MAX_REQUESTS);
  localparam logic [STL_W-1:0] STL_LIM = STL_W'(MAX_STALL);
  localparam logic [DLY_W-1:0] DLY_LIM = DLY_W'(MAX_ACK_DELAY);

  logic              r_pv;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_dat;
  logic              r_stalled;
  logic [CNT_W-1:0]  r_nreqs;
  logic [CNT_W-1:0]  r_nacks;
  logic [STL_W-1:0]  r_stall;
  logic [DLY_W-1:0]  r_wait;
  logic [OUT_W-1:0]  r_out;
  logic [8:0]        r_viol;
  logic [3:0]        r_first;
  logic [15:0]       r_xact;

  logic              w_req;
  logic              w_rsp;
  logic              w_zero;
  logic              w_pend;
  logic [CNT_W-1:0]  w_nreqs_nxt;
  logic [CNT_W-1:0]  w_nacks_nxt;
  logic [CNT_W:0]    w_diff;
  logic [STL_W-1:0]  w_stall_nxt;
  logic [DLY_W-1:0]  w_wait_nxt;
  logic              w_chg;
  logic [8:0]        w_rules;
  logic [3:0]        w_first;
  logic              w_done;

  assign w_req  = CYC_I & STB_I & ~STALL_O;
  assign w_rsp  = ACK_O | ERR_O;
  assign w_zero = (r_nreqs == r_nacks);
  assign w_pend = (r_nreqs > r_nacks);

  // Counters restart after any cycle without CYC and saturate, never wrap.
  always_comb begin
    w_nreqs_nxt = '0;
    w_nacks_nxt = '0;
    if (CYC_I) begin
      w_nreqs_nxt = r_nreqs;
      w_nacks_nxt = r_nacks;
      if (w_req && r_nreqs != CNT_MAX)
        w_nreqs_nxt = r_nreqs + 1'b1;
      if (w_rsp && r_nacks != CNT_MAX)
        w_nacks_nxt = r_nacks + 1'b1;
    end
  end

  assign w_diff = {1'b0, w_nreqs_nxt} - {1'b0, w_nacks_nxt};

  always_comb begin
    w_stall_nxt = '0;
    if (STB_I && STALL_O)
      w_stall_nxt = (r_stall == STL_LIM) ? r_stall
                                         : r_stall + 1'b1;
  end

  always_comb begin
    w_wait_nxt = '0;
    if (CYC_I && !STB_I && !w_rsp && w_pend)
      w_wait_nxt = (r_wait == DLY_LIM) ? r_wait
                                       : r_wait + 1'b1;
  end

  assign w_chg = (STB_I != r_stb) | (ADR_I != r_adr)
               | (SEL_I != r_sel) | (WE_I != r_we)
               | (WE_I & (DAT_I != r_dat));

  always_comb begin
    w_rules    = '0;
    w_rules[0] = STB_I & ~CYC_I;
    w_rules[1] = r_pv & r_stalled & w_chg;
    w_rules[2] = r_pv & r_stb & STB_I & (WE_I != r_we);
    w_rules[3] = STB_I & WE_I & (SEL_I == '0);
    w_rules[4] = (w_rsp & r_pv & ~r_cyc)
               | (w_rsp & w_zero & ~w_req)
               | (ACK_O & ERR_O);
    w_rules[5] = (MAX_STALL != 0) && (w_stall_nxt == STL_LIM);
    w_rules[6] = (MAX_ACK_DELAY != 0) && (w_wait_nxt == DLY_LIM);
    w_rules[7] = (w_req & (r_nreqs == REQ_LIM))
               | (r_nacks > r_nreqs);
`ifdef WB_MON_RMW_EN
    w_rules[8] = 1'b0;
`else
    w_rules[8] = CYC_I & ~STB_I & w_zero;
`endif
  end

  always_comb begin
    w_first = 4'hF;
    for (int i = 8; i >= 0; i--)
      if (w_rules[i]) w_first = 4'(i);
  end

  // A cycle counts only if it closes balanced and raises no new flag.
  assign w_done = r_cyc & ~CYC_I & w_zero & (r_nreqs != '0)
                & ((w_rules & ~r_viol) == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pv      <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_sel     <= '0;
      r_dat     <= '0;
      r_stalled <= 1'b0;
      r_nreqs   <= '0;
      r_nacks   <= '0;
      r_stall   <= '0;
      r_wait    <= '0;
      r_out     <= '0;
    end else begin
      r_pv      <= 1'b1;
      r_cyc     <= CYC_I;
      r_stb     <= STB_I;
      r_we      <= WE_I;
      r_adr     <= ADR_I;
      r_sel     <= SEL_I;
      r_dat     <= DAT_I;
      r_stalled <= CYC_I & STB_I & STALL_O;
      r_nreqs   <= w_nreqs_nxt;
      r_nacks   <= w_nacks_nxt;
      r_stall   <= w_stall_nxt;
      r_wait    <= w_wait_nxt;
      r_out     <= OUT_W'(w_diff);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_viol  <= '0;
      r_first <= 4'hF;
      r_xact  <= '0;
    end else if (clear_i) begin
      r_viol  <= w_rules;
      r_first <= w_first;
      r_xact  <= '0;
    end else begin
      r_viol <= r_viol | w_rules;
      if (r_first == 4'hF)
        r_first <= w_first;
      if (w_done)
        r_xact <= r_xact + 16'd1;
    end
  end

  assign viol_o        = r_viol;
  assign first_viol_o  = r_first;
  assign outstanding_o = r_out;
  assign xact_cnt_o    = r_xact;

endmodule

// File: tb/tb_wb_pipe_monitor.sv
// Scoreboard bench for wb_pipe_monitor (MAX_REQUESTS=2).
// Expectations follow WB_MON_RMW_EN when it is defined.
module tb_wb_pipe_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc, stb, we, stall, ack, err, clr;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [8:0]  viol;
  logic [3:0]  first;
  logic [2:0]  outs;
  logic [15:0] xact;

  always #5 clk = ~clk;

`ifdef WB_MON_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [8:0]  viol;
    logic [3:0]  first;
    logic [15:0] xact;
    logic [2:0]  outs;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_pipe_monitor #(
    .ADDR_W(32), .DATA_W(32), .MAX_REQUESTS(2),
    .MAX_STALL(4), .MAX_ACK_DELAY(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .SEL_I(sel), .DAT_I(dat),
    .STALL_O(stall), .ACK_O(ack), .ERR_O(err),
    .clear_i(clr),
    .viol_o(viol), .first_viol_o(first),
    .outstanding_o(outs), .xact_cnt_o(xact)
  );

  task automatic push(input string n, input logic [8:0] v,
                      input logic [3:0] f, input logic [15:0] x,
                      input logic [2:0] o);
    exp_t t;
    t.name = n; t.viol = v; t.first = f; t.xact = x; t.outs = o;
    sb.push_back(t);
  endtask

  // One bus cycle; returns 1ns after the edge that ends it.
  task automatic bus(input logic c, s, w, input logic [31:0] a,
                     input logic [3:0] sl,
                     input logic st, ak, er);
    cyc = c; stb = s; we = w; adr = a; sel = sl;
    dat = a ^ 32'hA5A5_0000;
    stall = st; ack = ak; err = er;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus(0, 0, 0, 32'h0, 4'hF, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc = 0; stb = 0; we = 0; adr = '0; sel = 4'hF; dat = '0;
    stall = 0; ack = 0; err = 0; clr = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus(0, 1, 0, 32'h8, 4'hF, 0, 0, 0);
    push("reset", 9'h000, 4'hF, 16'd0, 3'd0);
    rst_n = 1'b0;
    #2;
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    push("read_issue", 9'h000, 4'hF, 16'd0, 3'd1);
    push("read_done", 9'h000, 4'hF, 16'd1, 3'd0);
    bus(1, 1, 0, 32'h10, 4'hF, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    bus(1, 0, 0, 32'h10, 4'hF, 0, 0, 0);
    bus(1, 0, 0, 32'h10, 4'hF, 0, 1, 0);
    idle();
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_back_to_back();
    push("b2b", 9'h000, 4'hF, 16'd2, 3'd0);
    bus(1, 1, 0, 32'h20, 4'hF, 0, 0, 0);
    bus(1, 1, 0, 32'h24, 4'hF, 0, 1, 0);
    bus(1, 0, 0, 32'h24, 4'hF, 0, 1, 0);
    idle();
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_stall_stable();
    do_reset();
    push("stall_adr", 9'h002, 4'h1, 16'd0, 3'd0);
    bus(1, 1, 0, 32'h10, 4'hF, 1, 0, 0);
    bus(1, 1, 0, 32'h14, 4'hF, 1, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_pipeline_limit();
    do_reset();
    push("pipe_two", 9'h000, 4'hF, 16'd0, 3'd2);
    push("pipe_three", 9'h080, 4'h7, 16'd0, 3'd3);
    bus(1, 1, 0, 32'h20, 4'hF, 0, 0, 0);
    bus(1, 1, 0, 32'h24, 4'hF, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    bus(1, 1, 0, 32'h28, 4'hF, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_stall_timeout();
    do_reset();
    push("stall_3", 9'h000, 4'hF, 16'd0, 3'd0);
    push("stall_4", 9'h020, 4'h5, 16'd0, 3'd0);
    for (int i = 0; i < 3; i++)
      bus(1, 1, 0, 32'h30, 4'hF, 1, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    bus(1, 1, 0, 32'h30, 4'hF, 1, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_ack_timeout();
    do_reset();
    push("wait_7", 9'h000, 4'hF, 16'd0, 3'd1);
    push("wait_8", 9'h040, 4'h6, 16'd0, 3'd1);
    bus(1, 1, 0, 32'h40, 4'hF, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      bus(1, 0, 0, 32'h40, 4'hF, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    bus(1, 0, 0, 32'h40, 4'hF, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_spurious_ack();
    do_reset();
    push("spur_ack", 9'h010, 4'h4, 16'd0, 3'd0);
    idle();
    bus(0, 0, 0, 32'h0, 4'hF, 0, 1, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    do_reset();
    push("ack_and_err", 9'h010, 4'h4, 16'd0, 3'd0);
    bus(1, 1, 0, 32'h50, 4'hF, 0, 0, 0);
    bus(1, 0, 0, 32'h50, 4'hF, 0, 1, 1);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_err_abort();
    do_reset();
    push("err_abort", 9'h000, 4'hF, 16'd0, 3'd0);
    bus(1, 1, 0, 32'h60, 4'hF, 0, 0, 0);
    bus(1, 1, 0, 32'h64, 4'hF, 0, 0, 0);
    bus(1, 0, 0, 32'h64, 4'hF, 0, 0, 1);
    idle();
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_sel_zero();
    do_reset();
    push("sel_zero", 9'h008, 4'h3, 16'd0, 3'd1);
    bus(1, 1, 1, 32'h70, 4'h0, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  task automatic test_idle_and_clear();
    do_reset();
    push("idle_gap", RMW ? 9'h000 : 9'h100,
         RMW ? 4'hF : 4'h8, 16'd0, 3'd0);
    push("clear_vs_rule", 9'h001, 4'h0, 16'd0, 3'd0);
    push("clear", 9'h000, 4'hF, 16'd0, 3'd0);
    bus(1, 1, 0, 32'h80, 4'hF, 0, 0, 0);
    bus(1, 0, 0, 32'h80, 4'hF, 0, 1, 0);
    bus(1, 0, 0, 32'h80, 4'hF, 0, 0, 0);
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    idle();
    clr = 1'b1;
    bus(0, 1, 0, 32'h84, 4'hF, 0, 0, 0);
    clr = 1'b0;
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
    clr = 1'b1;
    idle();
    clr = 1'b0;
    e = sb.pop_front(); n_chk++;
    if ({viol, first, xact, outs} !==
        {e.viol, e.first, e.xact, e.outs}) begin
      n_fail++;
      $display("FAIL %s: got v=%h f=%h x=%0d o=%0d want v=%h f=%h x=%0d o=%0d",
               e.name, viol, first, xact, outs,
               e.viol, e.first, e.xact, e.outs);
    end
  endtask

  initial begin
    cyc = 0; stb = 0; we = 0; adr = '0; sel = 4'hF; dat = '0;
    stall = 0; ack = 0; err = 0; clr = 0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall_stable();
    test_pipeline_limit();
    test_stall_timeout();
    test_ack_timeout();
    test_spurious_ack();
    test_err_abort();
    test_sel_zero();
    test_idle_and_clear();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d entries want 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_pipe_monitor.md
Name: wb_pipe_monitor

Overview:
Synthesizable, parametrised run-time protocol monitor for the pipelined Wishbone B4 interface between a master and our slave transactors. It succeeds the fixed 32-bit, ACK-only formal checker: widths and limits are generic, and it adds ERR responses, sticky per-rule violation flags, a first-violation capture and a completed-cycle counter. It is a passive tap on the bus and is instantiated next to a slave transactor in simulation and on FPGA debug builds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8; SEL_W = DATA_W/8
MAX_REQUESTS, 8, maximum requests per bus cycle (>=1)
MAX_STALL, 4, maximum consecutive stalled STB cycles; 0 disables rule 5
MAX_ACK_DELAY, 8, maximum idle wait for a response; 0 disables rule 6

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
CYC_I  in  1  bus cycle
STB_I  in  1  strobe
WE_I  in  1  write enable
ADR_I  in  ADDR_W  address
SEL_I  in  SEL_W  byte selects
DAT_I  in  DATA_W  write data
STALL_O  in  1  slave stall (observed)
ACK_O  in  1  slave acknowledge (observed)
ERR_O  in  1  slave error (observed)
clear_i  in  1  synchronous clear of sticky state and counters
viol_o  out  9  sticky violation flags, bit n = rule n
first_viol_o  out  4  index of the first rule to fire; 4'hF = none
outstanding_o  out  clog2(MAX_REQUESTS+1)+1  nreqs - nacks
xact_cnt_o  out  16  count of cleanly completed bus cycles

Behaviour:
- Clock and reset: single clock CLK; reset RST_N is asynchronous and active-low. Reset drives viol_o=0, first_viol_o=4'hF, outstanding_o=0, xact_cnt_o=0, and clears all internal counters and the past-value registers.
- Definitions:
  - req = CYC_I & STB_I & !STALL_O
  - rsp = ACK_O | ERR_O
- Counters:
  - nreqs increments on req; nacks increments on rsp.
  - Both are cleared on the clock after any cycle with CYC_I=0.
  - Both saturate at 2*MAX_REQUESTS; they do not wrap.
- Rules, evaluated every cycle from the current inputs plus registered previous-cycle values. Rules that reference past values are suppressed on the first cycle after reset.
  - 0: STB_I & !CYC_I.
  - 1: previous cycle CYC&STB&STALL, but STB, ADR, SEL or WE changed, or DAT changed while WE=1.
  - 2: STB_I on two consecutive cycles with WE_I changed.
  - 3: STB_I & WE_I & SEL_I==0.
  - 4: rsp when CYC_I was low last cycle, or rsp with outstanding==0 and not req this cycle.
  - 5: stall counter (increments on STB&STALL, else cleared) reaches MAX_STALL.
  - 6: wait counter (increments on CYC & !STB & !rsp & outstanding>0, else cleared) reaches MAX_ACK_DELAY.
  - 7: req when nreqs==MAX_REQUESTS, or nacks>nreqs.
  - 8: idle cycle, CYC_I & !STB_I & outstanding==0 (see optional feature).
  - ACK_O & ERR_O together also counts as rule 4.
- Reporting latency:
  - A rule firing in cycle t sets its viol_o bit at the clock edge ending t; the bit is visible in t+1.
  - first_viol_o loads only while it equals 4'hF. If several rules fire in the same cycle, the lowest index wins.
- xact_cnt_o:
  - Increments, wrapping, on a CYC_I falling edge when nreqs==nacks, nreqs>0, and no viol_o bit changed during that cycle.
  - An ERR response counts as a response.
  - Dropping CYC_I after ERR with requests still outstanding is legal and does not count.
- clear_i:
  - Zeroes viol_o and xact_cnt_o and sets first_viol_o=4'hF at the next edge.
  - Bus tracking counters are unaffected.
  - If clear_i is high in the same cycle a rule fires, the rule wins: its bit is set and first_viol_o loads it.
- outstanding_o: registered value of nreqs - nacks.

Optional Feature:
WB_MON_RMW_EN
- Defined: rule 8 is disabled (viol_o[8] is tied to 0), so masters may hold CYC across idle gaps for read-modify-write.
- Undefined: rule 8 is active.

Test Plan:
- Single-cycle reset: one read at ADR=0x10 (STB 1 cycle), ACK 2 cycles later, CYC drops -> viol_o=0, xact_cnt_o=1, first_viol_o=4'hF.
- Stall stability: STB with STALL=1, then ADR changes 0x10->0x14 on the next cycle -> viol_o[1]=1, first_viol_o=1.
- Pipeline limit: with MAX_REQUESTS=2, three unstalled requests in one CYC -> viol_o[7]=1 one cycle after the third; outstanding_o reads 2 before it.
- Timeouts: with MAX_STALL=4, STALL held 4 cycles under STB -> viol_o[5]=1; with MAX_ACK_DELAY=8, no response for 8 idle cycles -> viol_o[6]=1.
- Error responses: spurious ACK with CYC low the previous cycle -> viol_o[4]=1. Separately, ERR on the first of 2 requests, then CYC drops -> no violation, xact_cnt_o unchanged.
- Idle gap and clear: idle gap of 1 cycle inside CYC -> viol_o[8]=1 without WB_MON_RMW_EN, 0 with it. Then pulse clear_i -> viol_o=0, first_viol_o=4'hF.
